// File: rtl/wb_ser_pkg.sv
// Shared definitions for the Wishbone serializer: register map, CTRL/STATUS bit
// positions and the shifter state encoding.
package wb_ser_pkg;

    typedef enum logic [1:0] {
        ADR_TXDATA = 2'd0,
        ADR_CTRL   = 2'd1,
        ADR_STATUS = 2'd2,
        ADR_RSVD   = 2'd3
    } adr_e;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_LSB_BIT   = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int CTRL_DIV_LSB   = 8;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_LEVEL_LSB = 16;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port: pop_data always presents the oldest
// entry, so a pop and the consumer's load of that word happen on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_reg == FULL_LEVEL);
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_serializer_fifo.sv
// Wishbone classic slave feeding a word FIFO into a programmable-rate serial shifter.
// Define SER_IRQ_EN to enable the "all data sent" interrupt and the CTRL.IE bit.
module wb_serializer_fifo
    import wb_ser_pkg::*;
#(
    parameter int DW    = 32,
    parameter int SW    = 16,
    parameter int DEPTH = 8,
    parameter int DIV_W = 8
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    input  logic [1:0]    ADR_I,
    input  logic [DW-1:0] DAT_I,
    output logic [DW-1:0] DAT_O,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          data_o,
    output logic          ena_o,
    output logic          irq_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = (SW > 1) ? $clog2(SW) : 1;

    adr_e            adr;
    logic            req;
    logic            bus_err;
    logic            push;
    logic            pop;
    logic            ctrl_wr;
    logic [DW-1:0]   ctrl_rd;
    logic [DW-1:0]   status_rd;
    logic [DW-1:0]   rd_data;

    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;
    logic [SW-1:0]   fifo_dout;

    logic            ctrl_en_reg;
    logic            ctrl_lsb_reg;
    logic            ctrl_ie;
    logic [DIV_W-1:0] ctrl_div_reg;

    state_e          state_reg;
    logic [SW-1:0]   shreg_reg;
    logic [SW-1:0]   shreg_shift;
    logic [BW-1:0]   bitcnt_reg;
    logic [DIV_W-1:0] divcnt_reg;
    logic [DIV_W-1:0] div_cur_reg;
    logic            lsb_cur_reg;
    logic            word_done;

    logic            unused_dat;
    assign unused_dat = ^{DAT_I[DW-1:CTRL_DIV_LSB+DIV_W], DAT_I[CTRL_DIV_LSB-1:CTRL_IE_BIT]};

    assign adr = adr_e'(ADR_I);

    always_comb begin
        req     = CYC_I & STB_I & ~ACK_O & ~ERR_O;
        bus_err = 1'b0;
        case (adr)
            ADR_TXDATA: bus_err = WE_I & fifo_full;
            ADR_CTRL:   bus_err = 1'b0;
            ADR_STATUS: bus_err = WE_I;
            ADR_RSVD:   bus_err = 1'b1;
            default:    bus_err = 1'b1;
        endcase
        push    = req & WE_I & (adr == ADR_TXDATA) & ~fifo_full;
        ctrl_wr = req & WE_I & (adr == ADR_CTRL);
    end

    always_comb begin
        ctrl_rd                               = '0;
        ctrl_rd[CTRL_EN_BIT]                  = ctrl_en_reg;
        ctrl_rd[CTRL_LSB_BIT]                 = ctrl_lsb_reg;
        ctrl_rd[CTRL_IE_BIT]                  = ctrl_ie;
        ctrl_rd[CTRL_DIV_LSB +: DIV_W]        = ctrl_div_reg;

        status_rd                             = '0;
        status_rd[STAT_BUSY_BIT]              = (state_reg != S_IDLE);
        status_rd[STAT_FULL_BIT]              = fifo_full;
        status_rd[STAT_EMPTY_BIT]             = fifo_empty;
        status_rd[STAT_LEVEL_LSB +: LW]       = fifo_level;

        rd_data = '0;
        case (adr)
            ADR_CTRL:   rd_data = ctrl_rd;
            ADR_STATUS: rd_data = status_rd;
            default:    rd_data = '0;
        endcase
    end

    // Bus termination and the CTRL register; side effects land on the request edge.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ACK_O        <= 1'b0;
            ERR_O        <= 1'b0;
            DAT_O        <= '0;
            ctrl_en_reg  <= 1'b0;
            ctrl_lsb_reg <= 1'b0;
            ctrl_div_reg <= '0;
        end else begin
            ACK_O <= req & ~bus_err;
            ERR_O <= req & bus_err;
            DAT_O <= (req & ~WE_I & ~bus_err) ? rd_data : '0;
            if (ctrl_wr) begin
                ctrl_en_reg  <= DAT_I[CTRL_EN_BIT];
                ctrl_lsb_reg <= DAT_I[CTRL_LSB_BIT];
                ctrl_div_reg <= DAT_I[CTRL_DIV_LSB +: DIV_W];
            end
        end
    end

`ifdef SER_IRQ_EN
    logic ctrl_ie_reg;
    logic irq_reg;

    assign ctrl_ie = ctrl_ie_reg;
    assign irq_o   = irq_reg;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ctrl_ie_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_ie_reg <= DAT_I[CTRL_IE_BIT];
            end
            irq_reg <= ctrl_ie_reg & fifo_empty & (state_reg == S_IDLE);
        end
    end
`else
    assign ctrl_ie = 1'b0;
    assign irq_o   = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (SW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk       (CLK_I),
        .srst      (RST_I),
        .push      (push),
        .push_data (DAT_I[SW-1:0]),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign word_done   = (state_reg == S_SHIFT) && (divcnt_reg == '0) && (bitcnt_reg == '0);
    // A finishing word and the next load share one edge, so frames stream with no gap.
    assign pop         = ctrl_en_reg & ~fifo_empty & ((state_reg == S_IDLE) | word_done);
    assign shreg_shift = lsb_cur_reg ? (shreg_reg >> 1) : (shreg_reg << 1);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg   <= S_IDLE;
            shreg_reg   <= '0;
            bitcnt_reg  <= '0;
            divcnt_reg  <= '0;
            div_cur_reg <= '0;
            lsb_cur_reg <= 1'b0;
            data_o      <= 1'b0;
            ena_o       <= 1'b0;
        end else if (pop) begin
            state_reg   <= S_SHIFT;
            shreg_reg   <= fifo_dout;
            bitcnt_reg  <= BW'(SW - 1);
            divcnt_reg  <= ctrl_div_reg;
            div_cur_reg <= ctrl_div_reg;
            lsb_cur_reg <= ctrl_lsb_reg;
            data_o      <= ctrl_lsb_reg ? fifo_dout[0] : fifo_dout[SW-1];
            ena_o       <= 1'b1;
        end else if (state_reg == S_SHIFT) begin
            if (divcnt_reg == '0) begin
                divcnt_reg <= div_cur_reg;
                if (bitcnt_reg != '0) begin
                    shreg_reg  <= shreg_shift;
                    bitcnt_reg <= bitcnt_reg - BW'(1);
                    data_o     <= lsb_cur_reg ? shreg_shift[0] : shreg_shift[SW-1];
                end else begin
                    state_reg <= S_IDLE;
                    data_o    <= 1'b0;
                    ena_o     <= 1'b0;
                end
            end else begin
                divcnt_reg <= divcnt_reg - DIV_W'(1);
            end
        end
    end

endmodule
